// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC1175 front end: reduction
// modes, the per-mode accumulator reload value and a constant log2 helper.
package adc_pkg;

  typedef enum logic [1:0] {
    MODE_SAMPLE = 2'd0,
    MODE_AVG    = 2'd1,
    MODE_MAX    = 2'd2,
    MODE_MIN    = 2'd3
  } adc_mode_e;

  // Widest accumulator any instance may ask for; callers truncate the
  // neutral value down to their own accumulator width.
  localparam int NEUTRAL_W = 64;

  // Reload value for an accumulator at the start of a window: MIN starts
  // from all-ones so the first sample always wins, every other mode from 0.
  function automatic logic [NEUTRAL_W-1:0] neutral(input logic [1:0] mode);
    return (mode == MODE_MIN) ? '1 : '0;
  endfunction

  // Ceiling log2 usable in constant expressions (clog2(1) = 0).
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adc_clk_div.sv
// ADC clock generator: divides clk_i by 2*decimation_factor (or passes it
// straight through when the factor is 0) and flags the clk_i edge on which
// the generated clock rises, which is when the ADC bus is safe to capture.
module adc_clk_div #(
  parameter int DF_WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic [DF_WIDTH-1:0] decimation_factor,
  output logic                clk_o,
  output logic                smp
);

  logic [DF_WIDTH-1:0] counter_q;
  logic [DF_WIDTH-1:0] counter_d;
  logic                clk_o_div_q;
  logic                clk_o_div_d;
  logic                df_zero;
  logic [DF_WIDTH-1:0] df_last;

  // Next divider state and the capture strobe.
  // NOTE: every always_comb output gets a default on entry, so no path can leave it unassigned and infer a latch.
  always_comb begin
    counter_d   = counter_q;
    clk_o_div_d = clk_o_div_q;
    df_zero     = (decimation_factor == '0);
    df_last     = decimation_factor - DF_WIDTH'(1);
    smp         = df_zero | ((counter_q == df_last) & ~clk_o_div_q);

    if (df_zero) begin
      counter_d = '0;
    end else if (counter_q >= decimation_factor) begin
      // Factor was lowered below the running count: resync without toggling
      // so clk_o never sees a short pulse.
      counter_d = '0;
    end else if (counter_q == df_last) begin
      counter_d   = '0;
      clk_o_div_d = ~clk_o_div_q;
    end else begin
      counter_d = counter_q + DF_WIDTH'(1);
    end
  end

  // Divider state register.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      counter_q   <= '0;
      clk_o_div_q <= 1'b0;
    end else begin
      counter_q   <= counter_d;
      clk_o_div_q <= clk_o_div_d;
    end
  end

  // Pass-through keeps full-rate sampling possible; held low in reset when dividing.
  assign clk_o = df_zero ? clk_i : clk_o_div_q;

endmodule

// File: rtl/adc_interface_mc.sv
// Multi-channel ADC1175 interface: one shared ADC clock, simultaneous capture
// of every channel, per-channel windowed reduction (sample/avg/max/min) and a
// packed result presented over the SI ready/ack handshake with sticky overrun.
module adc_interface_mc
  import adc_pkg::*;
#(
  parameter  int DATA_WIDTH   = 8,
  parameter  int CHANNELS     = 2,
  parameter  int DF_WIDTH     = 32,
  parameter  int AVG_LOG2_MAX = 4,
  localparam int LW           = clog2(AVG_LOG2_MAX + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ADC_data,
  output logic                           ADC_oe,
  output logic                           clk_o,
  output logic [CHANNELS*DATA_WIDTH-1:0] SI_data,
  output logic                           SI_rdy,
  input  logic                           SI_ack,
  input  logic [DF_WIDTH-1:0]            decimation_factor,
  input  logic [1:0]                     mode,
  input  logic [LW-1:0]                  avg_log2,
  output logic                           overrun,
  input  logic                           overrun_clr
);

  localparam int ACC_W = DATA_WIDTH + AVG_LOG2_MAX;
  localparam int CNT_W = (AVG_LOG2_MAX > 0) ? AVG_LOG2_MAX : 1;
  localparam int RES_W = CHANNELS * DATA_WIDTH;

  logic             smp;
  logic [LW-1:0]    l_sat;
  logic [LW-1:0]    l_eff;
  logic [LW-1:0]    shift_l;
  logic             restart;
  logic             last;
  logic [CNT_W:0]   win_len;
  logic             new_res;
  logic             accept;
  logic             drop;
  logic [ACC_W-1:0] neutral_val;
  logic [RES_W-1:0] result;

  logic [1:0]       mode_q;
  logic [1:0]       mode_d;
  logic [LW-1:0]    l_q;
  logic [LW-1:0]    l_d;
  logic [CNT_W-1:0] acc_cnt_q;
  logic [CNT_W-1:0] acc_cnt_d;
  logic [RES_W-1:0] si_data_q;
  logic [RES_W-1:0] si_data_d;
  logic             si_rdy_q;
  logic             si_rdy_d;
  logic             overrun_q;
  logic             overrun_d;

  assign ADC_oe = 1'b0;

  adc_clk_div #(
    .DF_WIDTH (DF_WIDTH)
  ) u_clk_div (
    .clk_i             (clk_i),
    .rst_n             (rst_n),
    .decimation_factor (decimation_factor),
    .clk_o             (clk_o),
    .smp               (smp)
  );

  // Window control, config-change detection and the SI handshake.
  always_comb begin
    l_sat       = (avg_log2 > LW'(AVG_LOG2_MAX)) ? LW'(AVG_LOG2_MAX) : avg_log2;
    l_eff       = (mode == MODE_SAMPLE) ? '0 : l_sat;
    shift_l     = (mode == MODE_AVG) ? l_eff : '0;
    neutral_val = ACC_W'(neutral(mode));
    restart     = (mode != mode_q) | (l_sat != l_q);
    win_len     = (CNT_W + 1)'(1) << l_eff;
    last        = ({1'b0, acc_cnt_q} == (win_len - (CNT_W + 1)'(1)));
    new_res     = smp & last & ~restart;
    accept      = new_res & (~si_rdy_q | SI_ack);
    drop        = new_res & si_rdy_q & ~SI_ack;

    mode_d    = mode;
    l_d       = l_sat;
    acc_cnt_d = acc_cnt_q;
    if (restart) begin
      acc_cnt_d = '0;
    end else if (smp) begin
      acc_cnt_d = last ? '0 : acc_cnt_q + CNT_W'(1);
    end

    si_data_d = accept ? result : si_data_q;
    si_rdy_d  = si_rdy_q;
    if (accept) begin
      si_rdy_d = 1'b1;
    end else if (si_rdy_q && SI_ack) begin
      si_rdy_d = 1'b0;
    end

    // A drop in the same cycle as a clear keeps the flag set.
    overrun_d = drop | (overrun_q & ~overrun_clr);
  end

  // Control and handshake registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_SAMPLE;
      l_q       <= '0;
      acc_cnt_q <= '0;
      si_data_q <= '0;
      si_rdy_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      l_q       <= l_d;
      acc_cnt_q <= acc_cnt_d;
      si_data_q <= si_data_d;
      si_rdy_q  <= si_rdy_d;
      overrun_q <= overrun_d;
    end
  end

  assign SI_data = si_data_q;
  assign SI_rdy  = si_rdy_q;
  assign overrun = overrun_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [DATA_WIDTH-1:0] x;
    logic [ACC_W-1:0]      x_ext;
    logic [ACC_W-1:0]      step;
    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W-1:0]      acc_d;
    logic [DATA_WIDTH-1:0] res;

    // Fold this strobe's sample into the running value; the folded value is
    // also the result when this strobe closes the window.
    always_comb begin
      x     = ADC_data[k*DATA_WIDTH +: DATA_WIDTH];
      x_ext = ACC_W'(x);
      case (mode)
        MODE_MAX: step = (x_ext > acc_q) ? x_ext : acc_q;
        MODE_MIN: step = (x_ext < acc_q) ? x_ext : acc_q;
        default:  step = acc_q + x_ext;
      endcase
      res = DATA_WIDTH'(step >> shift_l);

      acc_d = acc_q;
      if (restart) begin
        acc_d = neutral_val;
      end else if (smp) begin
        acc_d = last ? neutral_val : step;
      end
    end

    // Per-channel accumulator.
    // NOTE: the accumulators are ordinary flops, not a memory, so they take the async reset like all other state.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    assign result[k*DATA_WIDTH +: DATA_WIDTH] = res;
  end

endmodule

// File: tb/tb_adc_interface_mc.sv
// Directed bench for adc_interface_mc: pass-through and divided clocks,
// SAMPLE/AVG/MAX/MIN windows, handshake back-pressure and overrun, config
// restarts, asynchronous reset and runtime divider reduction.
module tb_adc_interface_mc;

  logic        clk;
  logic        rst_n;
  logic [15:0] ADC_data;
  logic        ADC_oe;
  logic        clk_o;
  logic [15:0] SI_data;
  logic        SI_rdy;
  logic        SI_ack;
  logic [31:0] decimation_factor;
  logic [1:0]  mode;
  logic [2:0]  avg_log2;
  logic        overrun;
  logic        overrun_clr;

  int errors = 0;
  int checks = 0;

  adc_interface_mc dut (
    .clk_i             (clk),
    .rst_n             (rst_n),
    .ADC_data          (ADC_data),
    .ADC_oe            (ADC_oe),
    .clk_o             (clk_o),
    .SI_data           (SI_data),
    .SI_rdy            (SI_rdy),
    .SI_ack            (SI_ack),
    .decimation_factor (decimation_factor),
    .mode              (mode),
    .avg_log2          (avg_log2),
    .overrun           (overrun),
    .overrun_clr       (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe at df=1 when called right after a strobe edge: the first edge
  // lowers clk_o, the second raises it and captures {c1, c0}.
  task automatic push(input logic [7:0] c0, input logic [7:0] c1);
    ADC_data = {c1, c0};
    tick();
    tick();
  endtask

  logic [4:0] exp_clk;

  initial begin
    rst_n             = 1'b0;
    ADC_data          = '0;
    SI_ack            = 1'b0;
    decimation_factor = '0;
    mode              = 2'd0;
    avg_log2          = '0;
    overrun_clr       = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_data", SI_data, 32'h0);
    check("rst_rdy", SI_rdy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_oe", ADC_oe, 1'b0);
    check("rst_clk_o_df0", clk_o, 1'b1);
    rst_n = 1'b1;

    // 1: df=0, SAMPLE, ack held high: result every cycle
    SI_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ADC_data = {8'(8'h80 + i), 8'(8'h10 + i)};
      tick();
      check("t1_data", SI_data, {16'h0, 8'(8'h80 + i), 8'(8'h10 + i)});
      check("t1_rdy", SI_rdy, 1'b1);
      check("t1_clk_o_hi", clk_o, 1'b1);
    end
    @(negedge clk);
    #1;
    check("t1_clk_o_lo", clk_o, 1'b0);
    check("t1_overrun", overrun, 1'b0);

    // 5: back-pressure and overrun
    ADC_data = 16'h2120;
    tick();
    check("t5_first", SI_data, 32'h2120);
    check("t5_no_ovr", overrun, 1'b0);
    SI_ack   = 1'b0;
    ADC_data = 16'h3130;
    tick();
    check("t5_hold", SI_data, 32'h2120);
    check("t5_ovr_set", overrun, 1'b1);
    ADC_data    = 16'h4140;
    overrun_clr = 1'b1;
    tick();
    check("t5_set_wins", overrun, 1'b1);
    check("t5_hold2", SI_data, 32'h2120);
    ADC_data = 16'h5150;
    SI_ack   = 1'b1;
    tick();
    check("t5_accept", SI_data, 32'h5150);
    check("t5_rdy", SI_rdy, 1'b1);
    check("t5_ovr_clr", overrun, 1'b0);
    overrun_clr = 1'b0;

    // 2: df=3, SAMPLE: clk_o period 6, capture on the rising edge only
    decimation_factor = 32'd3;
    ADC_data          = 16'h5AA5;
    tick();
    check("t2_ack_drop", SI_rdy, 1'b0);
    check("t2_keep", SI_data, 32'h5150);
    check("t2_clk_e1", clk_o, 1'b0);
    tick();
    check("t2_clk_e2", clk_o, 1'b0);
    tick();
    check("t2_clk_e3", clk_o, 1'b1);
    check("t2_data", SI_data, 32'h5AA5);
    check("t2_rdy", SI_rdy, 1'b1);
    ADC_data = 16'hC33C;
    tick();
    check("t2_clk_e4", clk_o, 1'b1);
    check("t2_rdy_e4", SI_rdy, 1'b0);
    tick();
    check("t2_clk_e5", clk_o, 1'b1);
    tick();
    check("t2_clk_e6", clk_o, 1'b0);
    tick();
    tick();
    check("t2_clk_e8", clk_o, 1'b0);
    tick();
    check("t2_clk_e9", clk_o, 1'b1);
    check("t2_data2", SI_data, 32'hC33C);
    check("t2_overrun", overrun, 1'b0);

    // 3: df=1, AVG, L=2
    decimation_factor = 32'd1;
    mode              = 2'd1;
    avg_log2          = 3'd2;
    push(8'd10, 8'hFF);
    push(8'd11, 8'hFF);
    push(8'd12, 8'hFF);
    check("t3_rdy_mid", SI_rdy, 1'b0);
    push(8'd14, 8'hFF);
    check("t3_avg", SI_data, 32'hFF0B);
    check("t3_rdy", SI_rdy, 1'b1);

    // 4: MAX window, partial MAX discarded by switch to MIN, then MIN windows
    mode     = 2'd2;
    avg_log2 = 3'd3;
    push(8'd3, 8'h40);
    push(8'd200, 8'h40);
    push(8'd7, 8'h40);
    push(8'd0, 8'h40);
    push(8'd9, 8'h40);
    push(8'd9, 8'h40);
    push(8'd1, 8'h40);
    check("t4_max_rdy_mid", SI_rdy, 1'b0);
    push(8'd5, 8'h40);
    check("t4_max", SI_data, 32'h40C8);
    check("t4_max_rdy", SI_rdy, 1'b1);
    push(8'd250, 8'h40);
    push(8'd250, 8'h40);
    push(8'd250, 8'h40);
    mode = 2'd3;
    push(8'd3, 8'h40);
    push(8'd200, 8'h40);
    push(8'd7, 8'h40);
    push(8'd0, 8'h40);
    push(8'd9, 8'h40);
    push(8'd9, 8'h40);
    push(8'd1, 8'h40);
    check("t4_restart_hold", SI_data, 32'h40C8);
    check("t4_restart_rdy", SI_rdy, 1'b0);
    push(8'd5, 8'h40);
    check("t4_min", SI_data, 32'h4000);
    for (int i = 0; i < 8; i++) begin
      push(8'(50 + i), 8'(8'h90 - i));
    end
    check("t4_min_reload", SI_data, 32'h8932);

    // 6: asynchronous reset mid-window and mid-handshake
    SI_ack = 1'b0;
    push(8'h70, 8'h70);
    push(8'h70, 8'h70);
    check("t6_pre_rdy", SI_rdy, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_data", SI_data, 32'h0);
    check("t6_async_rdy", SI_rdy, 1'b0);
    check("t6_async_ovr", overrun, 1'b0);
    check("t6_async_clk_o", clk_o, 1'b0);
    tick();
    check("t6_held_rdy", SI_rdy, 1'b0);
    rst_n    = 1'b1;
    SI_ack   = 1'b1;
    ADC_data = 16'h0000;
    tick();
    for (int i = 0; i < 8; i++) begin
      push(8'(100 - i), 8'(8'h10 + i));
      if (i == 6) begin
        check("t6_window_rdy", SI_rdy, 1'b0);
        check("t6_window_data", SI_data, 32'h0);
      end
    end
    check("t6_first_result", SI_data, 32'h105D);
    check("t6_first_rdy", SI_rdy, 1'b1);

    // 6: df reduced from 10 to 2 with counter at 7
    decimation_factor = 32'd10;
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    check("t6_df10_hold", clk_o, 1'b1);
    decimation_factor = 32'd2;
    exp_clk           = 5'b10011;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_resync_pos", clk_o, exp_clk[i]);
      @(negedge clk);
      #1;
      check("t6_resync_neg", clk_o, exp_clk[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_interface_mc.md
Name: adc_interface_mc

Overview:
Multi-channel successor to the single-channel ADC1175 interface.
- Drives one shared ADC clock to CHANNELS parallel ADC1175 devices and captures all channel buses on the same strobe.
- Reduces each window of 2^L captured samples per channel by a selectable mode: plain sample, average, max or min.
- Presents one packed result word to the acquisition buffer over the Simple Interface (SI) handshake, with sticky overrun reporting.

Parameters:
DATA_WIDTH, 8, bits per ADC sample.
CHANNELS, 2, number of ADC devices sharing clk_o.
DF_WIDTH, 32, width of decimation_factor.
AVG_LOG2_MAX, 4, maximum window exponent L; window length is up to 16 samples.
LW, $clog2(AVG_LOG2_MAX+1), width of avg_log2 (derived, not overridable).

Ports:
clk_i  in  1  FPGA clock; all logic is single-clock on posedge clk_i.
rst_n  in  1  reset, asynchronous assert, active-low.
ADC_data  in  CHANNELS*DATA_WIDTH  packed ADC buses; channel k is bits [k*DATA_WIDTH +: DATA_WIDTH].
ADC_oe  out  1  ADC output enable, active low; tied 0.
clk_o  out  1  ADC clock, shared by all channels.
SI_data  out  CHANNELS*DATA_WIDTH  reduced results, packed like ADC_data.
SI_rdy  out  1  result valid.
SI_ack  in  1  consumer acknowledge.
decimation_factor  in  DF_WIDTH  0 means clk_o=clk_i; otherwise f_clk_o = f_clk_i/(2*decimation_factor).
mode  in  2  0 SAMPLE, 1 AVG, 2 MAX, 3 MIN.
avg_log2  in  LW  window exponent L; values above AVG_LOG2_MAX saturate to AVG_LOG2_MAX.
overrun  out  1  sticky flag: a result was dropped.
overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, asynchronous): the following all go to 0.
  - counter, clk_o_div, acc_cnt
  - every accumulator
  - SI_data, SI_rdy, overrun
- During reset, clk_o = clk_i if decimation_factor==0, else 0.
- Divider when df!=0:
  - counter runs 0..df-1.
  - At counter==df-1: counter<=0 and clk_o_div toggles.
  - If counter>=df (df reduced at runtime), counter<=0 on the next edge with no toggle.
- clk_o is a combinational mux: clk_i when df==0, else clk_o_div.
- Strobe smp = (df==0) | (counter==df-1 & clk_o_div==0), i.e. the clk_i edge that raises clk_o. ADC_data is captured only on smp edges.
- Window: acc_cnt counts 0..2^L-1 on smp. last = (acc_cnt==2^L-1). SAMPLE mode forces L=0, so every smp is last.
- Per-channel accumulator, width DATA_WIDTH+AVG_LOG2_MAX, unsigned:
  - AVG: acc<=acc+x; result = (acc+x)>>L, truncated.
  - MAX: acc<=max(acc,x); result = max(acc,x).
  - MIN: same as MAX using min.
  - On a last smp the accumulator reloads from the neutral value: 0 for AVG/MAX, all-ones for MIN.
- Result commit happens on the same clk_i edge as the last smp: latency 0 cycles from the final sample edge to SI_rdy=1.
- Handshake: the result is accepted when SI_rdy==0, or when SI_rdy==1 & SI_ack==1.
  - Accepted: SI_data <= results, SI_rdy <= 1.
  - Ack with no new result: SI_rdy <= 0.
  - New result while SI_rdy==1 & SI_ack==0: result dropped, SI_data unchanged, overrun <= 1.
  - Same-cycle overrun_clr and a new drop: overrun stays 1 (set wins).
- SI_ack while SI_rdy==0 is ignored. Handshake is identical for df==0 and df!=0.
- Config change: mode or saturated L differing from its registered copy restarts the window.
  - acc_cnt<=0, accumulators <= neutral; any smp in that cycle is discarded.
  - SI_rdy and SI_data are unaffected.
- A df change does not restart the window.

Decomposition:
- Shared package adc_pkg holds:
  - MODE_SAMPLE=2'd0, MODE_AVG=2'd1, MODE_MAX=2'd2, MODE_MIN=2'd3
  - function neutral(mode)
  - clog2 helper
- One sub-module is natural: adc_clk_div (counter, clk_o_div, clk_o mux, smp output), reusable by later logic-analyser front ends.
- Per-channel reducers are a generate loop in the top, not a separate module.

Test Plan:
1. df=0, mode=SAMPLE, ADC ch0=0x10,0x11,... every cycle, SI_ack=1 -> clk_o follows clk_i; SI_rdy stays 1; SI_data tracks input each cycle; overrun=0.
2. df=3, mode=SAMPLE -> clk_o period 6 clk_i; one capture per clk_o rise; ch0=0xA5, ch1=0x5A give SI_data=0x5AA5.
3. df=1, mode=AVG, L=2, ch0 samples 10,11,12,14 -> single result 11 (47>>2) after the 4th strobe; ch1 all 0xFF gives 0xFF (no overflow).
4. mode=MAX then MIN, L=3, ch0 samples 3,200,7,0,9,9,1,5 -> results 200 and 0; switching mode mid-window discards partial data and the next result covers 8 fresh samples.
5. df=0, SAMPLE, SI_ack=0 for 3 cycles -> SI_data holds the first sample, overrun=1 on the second strobe; overrun_clr with a simultaneous drop keeps overrun=1.
6. Assert rst_n=0 mid-window and mid-handshake (SI_rdy=1) -> all outputs 0 immediately, without waiting for a clock edge; after release the first result appears after a full 2^L window; reducing df from 10 to 2 while counter=7 resyncs counter to 0 with no glitch pulse on clk_o.
